jk_bank_arbiter: RTL and testbench
==================================

# jk_bank_arbiter

Round-robin command arbiter and sequencer for a bank of WIDTH JK flip-flops that share one clock. Up to NREQ requesters each ask for one single-bit operation: hold/read, clear, set or toggle. The block grants one requester at a time and drives a one-cycle J/K pulse onto the addressed bit. It then samples the bank output and returns the resulting bit value with a done strobe. It sits between control logic and the JK register bank and is the only driver of the bank's j/k inputs.

## Interface
- NREQ, 4: number of requesters (2..8)
- WIDTH, 8: number of JK flops in the bank (1..32)
- IDXW, 3: bit-index width; must satisfy 2**IDXW >= WIDTH

- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- req  input  NREQ  request level, one bit per requester
- req_idx  input  NREQ*IDXW  target bit index; requester i uses slice [i*IDXW +: IDXW]
- req_op  input  NREQ*2  operation in {j,k} encoding (00 hold/read, 01 clear, 10 set, 11 toggle); requester i uses slice [i*2 +: 2]
- q_bank  input  WIDTH  current q outputs of the JK bank
- gnt  output  NREQ  one-hot grant, high for exactly one cycle
- j_vec  output  WIDTH  J inputs to the bank
- k_vec  output  WIDTH  K inputs to the bank
- done  output  1  one-cycle completion strobe
- done_id  output  clog2(NREQ), min 1  index of the completed requester
- rd_q  output  1  value of the target bit after the operation
- err  output  1  valid with done; 1 when req_idx >= WIDTH

## Operation
- All outputs are registered.
- Reset: state IDLE, rr pointer = NREQ-1 (requester 0 has priority first); gnt, j_vec, k_vec, done, done_id, rd_q and err are all 0.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If |req is 1, select the winner by round-robin: search starts at (ptr+1) mod NREQ and wraps.
  - Latch the winner's idx and op. Set gnt[winner]=1 and ptr=winner.
  - If idx < WIDTH: j_vec[idx]=op[1], k_vec[idx]=op[0]; all other bits 0.
  - If idx >= WIDTH: j_vec and k_vec stay 0, and the latched error flag is set.
  - Go to ISSUE.
  - If no request, stay in IDLE.
- ISSUE:
  - gnt, j_vec and k_vec are visible for this one cycle.
  - On the closing edge, clear gnt, j_vec and k_vec and go to WAIT.
- WAIT:
  - q_bank already reflects the operation, because the bank sampled on the edge that closed ISSUE.
  - On the closing edge, set done=1, done_id=winner, rd_q=q_bank[idx] (0 when in error), err=flag. Go to IDLE.
- In IDLE, done, rd_q and err are cleared after one cycle. A new arbitration may occur in the same IDLE cycle that done is high.
- Requester protocol:
  - Hold req, req_idx and req_op stable until gnt[i] is seen.
  - Deassert req in the cycle after gnt, or keep it high to request again.
  - Changing idx or op while waiting for a grant is legal; the value sampled on the grant edge is used.
- Op 00 leaves the bit unchanged (j=k=0) and serves as a read.
- The controller never drives more than one bit of j_vec or k_vec at a time.

## Timing
- Requests are sampled on edge E0 (FSM in IDLE).
- gnt and j/k are high from E0 to E1. The bank updates on E1.
- done, rd_q and err are high from E2 to E3.
- Latency from request sample to done: 2 cycles. Throughput: one operation per 3 cycles.
- Reset mid-operation (ISSUE or WAIT): the operation is aborted, no done is produced, and the next cycle is IDLE with all outputs 0.
- Reset does not touch the bank. If reset lands in ISSUE, the bank may still have applied the J/K pulse, because reset and that pulse share the same edge.
- Fairness: a requester that is continuously asserted is granted within NREQ arbitrations.
- Simultaneous requests after reset: requester 0 wins first, then 1, 2, 3.

## Test plan
- Reset, q_bank=0, WIDTH=8: req0 op=10 idx=3 → gnt=0001 and j_vec=0x08, k_vec=0x00 one cycle after the request edge; done=1, done_id=0, rd_q=1, err=0 two cycles after.
- With bit 3 = 1: toggle (11) idx=3, then read (00) idx=3 → first op drives j_vec=k_vec=0x08 and returns rd_q=0; read drives j_vec=k_vec=0 and returns rd_q=0.
- Requesters 0..3 all assert continuously, each op=10 at a distinct idx → grant order 0,1,2,3,0 every 3 cycles; done_id follows the same order.
- req2 with idx=9 (out of range for WIDTH=8) → j_vec=k_vec=0, done=1, err=1, rd_q=0; the bank is unchanged.
- Assert rst during WAIT of a set operation on idx=5 → no done pulse; all outputs 0 on the next cycle; the bank bit stays 1; the next request is granted normally with requester 0 priority.
- req1 asserted alone, then req3 asserted in the cycle done is high → req3 is granted in that same IDLE cycle (gnt=1000 on the following cycle) with no idle gap.

Source files
------------

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter and sequencer for a shared JK flop bank: grants one requester,
// pulses J/K on the addressed bit for one cycle, then returns the resulting bit value.
module jk_bank_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  parameter  int IDXW  = 3,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*IDXW-1:0] req_idx,
  input  logic [NREQ*2-1:0]    req_op,
  input  logic [WIDTH-1:0]     q_bank,
  output logic [NREQ-1:0]      gnt,
  output logic [WIDTH-1:0]     j_vec,
  output logic [WIDTH-1:0]     k_vec,
  output logic                 done,
  output logic [IDW-1:0]       done_id,
  output logic                 rd_q,
  output logic                 err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     win_q, win_d;
  logic [IDXW-1:0]    idx_q, idx_d;
  logic               flag_q, flag_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [WIDTH-1:0]   j_q, j_d;
  logic [WIDTH-1:0]   k_q, k_d;
  logic               done_q, done_d;
  logic [IDW-1:0]     done_id_q, done_id_d;
  logic               rd_bit_q, rd_bit_d;
  logic               err_q, err_d;

  logic               found;
  logic [IDW-1:0]     win_sel;
  logic [IDXW-1:0]    sel_idx;
  logic [1:0]         sel_op;
  logic               in_range;
  logic               sel_bit;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= IDW'(NREQ - 1);
      win_q     <= '0;
      idx_q     <= '0;
      flag_q    <= 1'b0;
      gnt_q     <= '0;
      j_q       <= '0;
      k_q       <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      rd_bit_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      idx_q     <= idx_d;
      flag_q    <= flag_d;
      gnt_q     <= gnt_d;
      j_q       <= j_d;
      k_q       <= k_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      rd_bit_q  <= rd_bit_d;
      err_q     <= err_d;
    end
  end

  // Round-robin pick: first asserted requester after the last winner, wrapping.
  always_comb begin
    found   = 1'b0;
    win_sel = ptr_q;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && req[(int'(ptr_q) + i) % NREQ]) begin
        found   = 1'b1;
        win_sel = IDW'((int'(ptr_q) + i) % NREQ);
      end
    end
  end

  assign sel_idx  = req_idx[int'(win_sel)*IDXW +: IDXW];
  assign sel_op   = req_op[int'(win_sel)*2 +: 2];
  assign in_range = (int'(sel_idx) < WIDTH);

  always_comb begin
    sel_bit = 1'b0;
    for (int b = 0; b < WIDTH; b++) begin
      if (int'(idx_q) == b) sel_bit = q_bank[b];
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    ptr_d     = ptr_q;
    win_d     = win_q;
    idx_d     = idx_q;
    flag_d    = flag_q;
    gnt_d     = '0;
    j_d       = '0;
    k_d       = '0;
    done_d    = 1'b0;
    done_id_d = '0;
    rd_bit_d  = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d  = NREQ'(1) << win_sel;
          ptr_d  = win_sel;
          win_d  = win_sel;
          idx_d  = sel_idx;
          flag_d = !in_range;
          if (in_range) begin
            j_d = WIDTH'(sel_op[1]) << sel_idx;
            k_d = WIDTH'(sel_op[0]) << sel_idx;
          end
        end
      end
      WAIT: begin
        // The bank already took the pulse on the edge that closed ISSUE.
        done_d    = 1'b1;
        done_id_d = win_q;
        rd_bit_d  = sel_bit & !flag_q;
        err_d     = flag_q;
      end
      default: ;
    endcase
  end

  assign gnt     = gnt_q;
  assign j_vec   = j_q;
  assign k_vec   = k_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign rd_q    = rd_bit_q;
  assign err     = err_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Scoreboard bench for jk_bank_arbiter: a transaction-level model predicts grants and
// completions; a negedge monitor compares them against the DUT driving a modelled JK bank.
module tb_jk_bank_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDXW  = 4;
  localparam int IDW   = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*IDXW-1:0] req_idx;
  logic [NREQ*2-1:0]    req_op;
  logic [WIDTH-1:0]     q_bank;
  logic [NREQ-1:0]      gnt;
  logic [WIDTH-1:0]     j_vec;
  logic [WIDTH-1:0]     k_vec;
  logic                 done;
  logic [IDW-1:0]       done_id;
  logic                 rd_q;
  logic                 err;

  jk_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_idx(req_idx), .req_op(req_op),
    .q_bank(q_bank), .gnt(gnt), .j_vec(j_vec), .k_vec(k_vec), .done(done),
    .done_id(done_id), .rd_q(rd_q), .err(err)
  );

  always #5 clk = ~clk;

  // The JK bank driven by the DUT
  initial q_bank = '0;
  always @(posedge clk) begin
    for (int b = 0; b < WIDTH; b++) begin
      case ({j_vec[b], k_vec[b]})
        2'b01:   q_bank[b] <= 1'b0;
        2'b10:   q_bank[b] <= 1'b1;
        2'b11:   q_bank[b] <= ~q_bank[b];
        default: q_bank[b] <= q_bank[b];
      endcase
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs as seen by the DUT on each rising edge
  logic [NREQ-1:0]      req_cap;
  logic [NREQ*IDXW-1:0] idx_cap;
  logic [NREQ*2-1:0]    op_cap;
  logic                 rst_cap;
  always @(posedge clk) begin
    req_cap <= req;
    idx_cap <= req_idx;
    op_cap  <= req_op;
    rst_cap <= rst;
  end

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           rd;
    logic           err;
  } exp_t;

  exp_t             sb[$];
  int               phase    = 0;        // 0 idle, 1 pulse cycle, 2 bank-settle cycle
  int               last_win = NREQ - 1;
  logic [WIDTH-1:0] exp_bank = '0;

  always @(negedge clk) begin : monitor
    int       w;
    int       idx;
    logic [1:0] op;
    logic [WIDTH-1:0] ej, ek;
    exp_t     e;
    if (rst_cap) begin
      check("reset_outputs", 32'({gnt, j_vec, k_vec, done, rd_q, err, done_id}), 0);
      phase    = 0;
      last_win = NREQ - 1;
      sb.delete();
    end else begin
      check("done_timing", 32'(done), 32'(phase == 2));
      if (done) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL done_unexpected: got done=1 expected no pending operation at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("done_id", 32'(done_id), 32'(e.id));
          check("rd_q", 32'(rd_q), 32'(e.rd));
          check("err", 32'(err), 32'(e.err));
        end
      end
      if (phase == 0) begin
        if (|req_cap) begin
          w = -1;
          for (int n = 1; n <= NREQ; n++) begin
            if (w < 0 && req_cap[(last_win + n) % NREQ]) w = (last_win + n) % NREQ;
          end
          idx = int'(idx_cap[w*IDXW +: IDXW]);
          op  = op_cap[w*2 +: 2];
          ej  = '0;
          ek  = '0;
          if (idx < WIDTH) begin
            ej[idx] = op[1];
            ek[idx] = op[0];
            case (op)
              2'b01:   exp_bank[idx] = 1'b0;
              2'b10:   exp_bank[idx] = 1'b1;
              2'b11:   exp_bank[idx] = ~exp_bank[idx];
              default: ;
            endcase
          end
          check("gnt", 32'(gnt), 32'(1 << w));
          check("j_vec", 32'(j_vec), 32'(ej));
          check("k_vec", 32'(k_vec), 32'(ek));
          e.id  = IDW'(w);
          e.err = (idx >= WIDTH);
          e.rd  = (idx < WIDTH) ? exp_bank[idx] : 1'b0;
          sb.push_back(e);
          last_win = w;
          phase    = 1;
        end else begin
          check("idle_outputs", 32'({gnt, j_vec, k_vec}), 0);
        end
      end else begin
        check("busy_outputs", 32'({gnt, j_vec, k_vec}), 0);
        phase = (phase == 1) ? 2 : 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input int idx, input int op);
    req[i]                   = v;
    req_idx[i*IDXW +: IDXW]  = IDXW'(idx);
    req_op[i*2 +: 2]         = 2'(op);
  endtask

  task automatic wait_gnt(input int i);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (gnt[i]) begin
        ok = 1'b1;
        break;
      end
    end
    check($sformatf("grant_wait_%0d", i), 32'(ok), 1);
  endtask

  task automatic issue(input int i, input int idx, input int op);
    set_req(i, 1'b1, idx, op);
    wait_gnt(i);
    req[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int order[$];
    logic [WIDTH-1:0] snap;
    rst     = 1'b1;
    req     = '0;
    req_idx = '0;
    req_op  = '0;
    tick();
    tick();
    check("reset_state", 32'({gnt, j_vec, k_vec, done, rd_q, err, done_id}), 0);
    rst = 1'b0;

    // Set bit 3
    issue(0, 3, 2);
    check("t1_gnt", 32'(gnt), 32'h1);
    check("t1_j", 32'(j_vec), 32'h08);
    check("t1_k", 32'(k_vec), 32'h00);
    tick();
    tick();
    check("t1_done", 32'(done), 1);
    check("t1_rd", 32'(rd_q), 1);
    check("t1_id", 32'(done_id), 0);
    check("t1_err", 32'(err), 0);
    tick();

    // Toggle then read bit 3
    issue(0, 3, 3);
    check("t2_j", 32'(j_vec), 32'h08);
    check("t2_k", 32'(k_vec), 32'h08);
    tick();
    tick();
    check("t2_toggle_rd", 32'(rd_q), 0);
    tick();
    issue(0, 3, 0);
    check("t2_read_jk", 32'({j_vec, k_vec}), 0);
    tick();
    tick();
    check("t2_read_done", 32'(done), 1);
    check("t2_read_rd", 32'(rd_q), 0);
    tick();

    // All four requesters held continuously
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 4 + i, 2);
    for (int c = 0; c < 16; c++) begin
      tick();
      for (int i = 0; i < NREQ; i++) if (gnt[i]) order.push_back(i);
    end
    req = '0;
    check("t3_grant_count", 32'(order.size()), 6);
    if (order.size() >= 5) begin
      check("t3_order0", 32'(order[0]), 0);
      check("t3_order1", 32'(order[1]), 1);
      check("t3_order2", 32'(order[2]), 2);
      check("t3_order3", 32'(order[3]), 3);
      check("t3_order4", 32'(order[4]), 0);
    end
    repeat (4) tick();

    // Out-of-range index
    snap = q_bank;
    issue(2, 9, 2);
    check("t4_jk", 32'({j_vec, k_vec}), 0);
    tick();
    tick();
    check("t4_done", 32'(done), 1);
    check("t4_err", 32'(err), 1);
    check("t4_rd", 32'(rd_q), 0);
    check("t4_bank", 32'(q_bank), 32'(snap));
    tick();

    // Reset landing in the settle cycle
    issue(0, 5, 2);
    tick();
    rst = 1'b1;
    tick();
    check("t5_outputs", 32'({gnt, j_vec, k_vec, done, rd_q, err, done_id}), 0);
    rst = 1'b0;
    check("t5_bank_bit", 32'(q_bank[5]), 1);
    set_req(0, 1'b1, 1, 0);
    set_req(1, 1'b1, 2, 0);
    tick();
    check("t5_priority", 32'(gnt), 32'h1);
    req[0] = 1'b0;
    wait_gnt(1);
    req[1] = 1'b0;
    repeat (3) tick();

    // Back-to-back: new grant in the done cycle
    issue(1, 0, 2);
    tick();
    tick();
    check("t6_done", 32'(done), 1);
    check("t6_id", 32'(done_id), 1);
    set_req(3, 1'b1, 6, 3);
    tick();
    check("t6_gnt", 32'(gnt), 32'h8);
    req[3] = 1'b0;
    repeat (3) tick();

    // Randomized traffic under the requester protocol
    repeat (3000) begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) begin
          set_req(i, 1'($urandom_range(0, 1)), $urandom_range(0, 9), $urandom_range(0, 3));
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          set_req(i, 1'b1, $urandom_range(0, 9), $urandom_range(0, 3));
        end else if (req[i] && $urandom_range(0, 7) == 0) begin
          set_req(i, 1'b1, $urandom_range(0, 9), $urandom_range(0, 3));
        end
      end
      tick();
    end
    req = '0;
    repeat (6) tick();
    check("scoreboard_empty", 32'(sb.size()), 0);
    check("bank_final", 32'(q_bank), 32'(exp_bank));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
